// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared definitions for the per-axis stepper controller:
//   - DATA_W       : width of the speed/position/count datapath
//   - DEF_*        : default timing constants and soft travel limits
//   - state_e      : controller state encoding
// -----------------------------------------------------------------------------
package stepper_pkg;

  localparam int DATA_W = 32;

  localparam int DEF_PULSE_WIDTH = 100;
  localparam int DEF_DIR_SETUP   = 50;
  localparam int DEF_MIN_PERIOD  = 200;
  localparam int DEF_JOG_PERIOD  = 100000;

  localparam logic signed [DATA_W-1:0] DEF_POS_MIN = -32'sd20000;
  localparam logic signed [DATA_W-1:0] DEF_POS_MAX = 32'sd20000;

  // Prefixed so the names do not collide with the DIR_SETUP timing parameter.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIR_SETUP,
    ST_HIGH,
    ST_LOW
  } state_e;

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Loadable down-counter shared by the DIR_SETUP, HIGH and LOW phases.
// Loading N-1 makes done assert in the N-th cycle after the load edge,
// so a phase that loads N-1 on entry lasts exactly N cycles.
// Ports:
//   clock, reset : system clock, async active-high reset
//   load         : load value on the next edge (overrides counting)
//   value        : value to load
//   done         : counter has reached zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module step_timer
  import stepper_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Saturates at zero so an idle timer keeps reporting done.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/stepper_axis_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_axis_ctrl
// Step/direction pulse generator for one stepper axis. Adds DIR setup time,
// a minimum step period, a signed position counter and soft travel limits.
// Ports:
//   clock, reset : system clock, async active-high reset
//   speed        : step period in cycles, 0 = stop
//   dir          : bit 0 = direction, 1 = positive
//   jog_pos/neg  : manual jog buttons (override speed/dir)
//   zero_pos     : synchronous strobe clearing the position counter
//   step_out     : STEP pin (registered)
//   dir_out      : DIR pin (registered)
//   position     : signed step position
//   step_count   : total pulses since reset, wraps
//   at_limit     : last decision was blocked by a soft limit
//   busy         : controller not idle
// -----------------------------------------------------------------------------
module stepper_axis_ctrl
  import stepper_pkg::*;
#(
  parameter int                         PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int                         DIR_SETUP   = DEF_DIR_SETUP,
  parameter int                         MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int                         JOG_PERIOD  = DEF_JOG_PERIOD,
  parameter logic signed [DATA_W-1:0]   POS_MIN     = DEF_POS_MIN,
  parameter logic signed [DATA_W-1:0]   POS_MAX     = DEF_POS_MAX
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        speed,
  input  logic [DATA_W-1:0]        dir,
  input  logic                     jog_pos,
  input  logic                     jog_neg,
  input  logic                     zero_pos,
  output logic                     step_out,
  output logic                     dir_out,
  output logic signed [DATA_W-1:0] position,
  output logic [DATA_W-1:0]        step_count,
  output logic                     at_limit,
  output logic                     busy
);

  localparam logic [DATA_W-1:0] PW_LOAD    = DATA_W'(PULSE_WIDTH - 1);
  localparam logic [DATA_W-1:0] DS_LOAD    = DATA_W'(DIR_SETUP - 1);
  localparam logic [DATA_W-1:0] PW_PLUS1   = DATA_W'(PULSE_WIDTH + 1);
  localparam logic [DATA_W-1:0] MIN_P      = DATA_W'(MIN_PERIOD);
  localparam logic [DATA_W-1:0] JOG_P      = DATA_W'(JOG_PERIOD);

  state_e                     state_q, state_d;
  logic                       step_out_q, step_out_d;
  logic                       dir_out_q, dir_out_d;
  logic                       at_limit_q, at_limit_d;
  logic [DATA_W-1:0]          period_q, period_d;
  logic                       pdir_q, pdir_d;
  logic signed [DATA_W-1:0]   position_q, position_d;
  logic [DATA_W-1:0]          step_count_q, step_count_d;

  logic [DATA_W-1:0]          req_period_raw;
  logic [DATA_W-1:0]          req_period;
  logic                       req_dir;
  logic                       blocked;
  logic                       decide;
  logic                       enter_high;
  logic                       step_dir;
  logic                       tmr_load;
  logic [DATA_W-1:0]          tmr_value;
  logic                       tmr_done;

  logic                       unused_dir_bits;
  assign unused_dir_bits = ^dir[DATA_W-1:1];

  step_timer #(.W(DATA_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // Command source: a single jog button overrides the program registers,
  // both buttons together mean stop. Short periods are clamped up.
  always_comb begin
    req_period_raw = speed;
    req_dir        = dir[0];
    if (jog_pos ^ jog_neg) begin
      req_period_raw = JOG_P;
      req_dir        = jog_pos;
    end else if (jog_pos && jog_neg) begin
      req_period_raw = '0;
    end
    req_period = req_period_raw;
    if ((req_period_raw != '0) && (req_period_raw < MIN_P)) begin
      req_period = MIN_P;
    end
    blocked = (req_dir && (position_q == POS_MAX)) ||
              (!req_dir && (position_q == POS_MIN));
  end

  // Next-state logic. Decisions happen in IDLE and in the last LOW cycle,
  // which keeps rising edges exactly P cycles apart under a steady command.
  always_comb begin
    state_d      = state_q;
    dir_out_d    = dir_out_q;
    at_limit_d   = at_limit_q;
    period_d     = period_q;
    pdir_d       = pdir_q;
    position_d   = position_q;
    step_count_d = step_count_q;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    enter_high   = 1'b0;
    step_dir     = pdir_q;

    decide = (state_q == ST_IDLE) || ((state_q == ST_LOW) && tmr_done);

    case (state_q)
      ST_DIR_SETUP: begin
        if (tmr_done) begin
          state_d    = ST_HIGH;
          tmr_load   = 1'b1;
          tmr_value  = PW_LOAD;
          enter_high = 1'b1;
        end
      end
      ST_HIGH: begin
        if (tmr_done) begin
          state_d   = ST_LOW;
          tmr_load  = 1'b1;
          tmr_value = period_q - PW_PLUS1;
        end
      end
      default: ;
    endcase

    if (decide) begin
      if (req_period == '0) begin
        state_d = ST_IDLE;
      end else if (blocked) begin
        state_d    = ST_IDLE;
        at_limit_d = 1'b1;
      end else begin
        at_limit_d = 1'b0;
        period_d   = req_period;
        pdir_d     = req_dir;
        if (req_dir != dir_out_q) begin
          state_d   = ST_DIR_SETUP;
          dir_out_d = req_dir;
          tmr_load  = 1'b1;
          tmr_value = DS_LOAD;
        end else begin
          state_d    = ST_HIGH;
          tmr_load   = 1'b1;
          tmr_value  = PW_LOAD;
          enter_high = 1'b1;
          step_dir   = req_dir;
        end
      end
    end

    if (enter_high) begin
      position_d   = step_dir ? (position_q + 32'sd1) : (position_q - 32'sd1);
      step_count_d = step_count_q + DATA_W'(1);
    end

    // Zeroing wins over a coincident step increment.
    if (zero_pos) begin
      position_d = '0;
    end

    step_out_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_out_q   <= 1'b0;
      dir_out_q    <= 1'b0;
      at_limit_q   <= 1'b0;
      period_q     <= '0;
      pdir_q       <= 1'b0;
      position_q   <= '0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      step_out_q   <= step_out_d;
      dir_out_q    <= dir_out_d;
      at_limit_q   <= at_limit_d;
      period_q     <= period_d;
      pdir_q       <= pdir_d;
      position_q   <= position_d;
      step_count_q <= step_count_d;
    end
  end

  assign step_out   = step_out_q;
  assign dir_out    = dir_out_q;
  assign position   = position_q;
  assign step_count = step_count_q;
  assign at_limit   = at_limit_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepper_axis_ctrl
// Directed bench for stepper_axis_ctrl. Two instances: a main axis with the
// default limits (jog period shortened to keep runs short) and a second axis
// with POS_MAX = 3 for the soft-limit and zeroing scenarios.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stepper_axis_ctrl;

   localparam int TB_JOG  = 3000;
   localparam int BOUND   = 20000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic [31:0] speed = '0;
   logic [31:0] dir = '0;
   logic        jogPos = 1'b0;
   logic        jogNeg = 1'b0;
   logic        zeroPos = 1'b0;
   logic        stepOut;
   logic        dirOut;
   logic signed [31:0] position;
   logic [31:0] stepCount;
   logic        atLimit;
   logic        busy;

   logic [31:0] limSpeed = '0;
   logic [31:0] limDir = '0;
   logic        limZero = 1'b0;
   logic        limStepOut;
   logic        limDirOut;
   logic signed [31:0] limPosition;
   logic [31:0] limStepCount;
   logic        limAtLimit;
   logic        limBusy;

   int passCount = 0;
   int checkCount = 0;

   always #5 clock = ~clock;

   stepper_axis_ctrl #(.JOG_PERIOD(TB_JOG)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .speed      (speed),
      .dir        (dir),
      .jog_pos    (jogPos),
      .jog_neg    (jogNeg),
      .zero_pos   (zeroPos),
      .step_out   (stepOut),
      .dir_out    (dirOut),
      .position   (position),
      .step_count (stepCount),
      .at_limit   (atLimit),
      .busy       (busy)
   );

   stepper_axis_ctrl #(.JOG_PERIOD(TB_JOG), .POS_MAX(32'sd3)) u_lim (
      .clock      (clock),
      .reset      (reset),
      .speed      (limSpeed),
      .dir        (limDir),
      .jog_pos    (1'b0),
      .jog_neg    (1'b0),
      .zero_pos   (limZero),
      .step_out   (limStepOut),
      .dir_out    (limDirOut),
      .position   (limPosition),
      .step_count (limStepCount),
      .at_limit   (limAtLimit),
      .busy       (limBusy)
   );

   // Drives the main axis command inputs.
   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                                input logic jp, input logic jn);
      speed  = s;
      dir    = d;
      jogPos = jp;
      jogNeg = jn;
   endtask

   // One comparison: counts it, and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag,
                  $signed(observed), $signed(expected));
   endtask

   // Counts falling edges until the selected STEP pin is seen high.
   task automatic waitRise(input bit lim, output int n);
      n = 0;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clock);
         n++;
         if (lim ? limStepOut : stepOut) break;
      end
   endtask

   // Called on the first sample of a pulse; returns its high time and the
   // spacing to the next rising edge (large values if nothing arrives).
   task automatic measurePeriod(output int highCycles, output int periodCycles);
      int lowCycles;
      highCycles = 1;
      lowCycles  = 1;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clock);
         if (stepOut) highCycles++;
         else break;
      end
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clock);
         if (!stepOut) lowCycles++;
         else break;
      end
      periodCycles = highCycles + lowCycles;
   endtask

   // Waits for the limit axis to return to idle.
   task automatic waitLimIdle();
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clock);
         if (!limBusy) break;
      end
   endtask

   // Directed sequence covering reset, steady stepping, reversal, clamp,
   // jog override, soft limits, zeroing and async reset.
   initial begin
      int n;
      int hi;
      int per;
      int rises;
      int firstRise;
      logic prev;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      checkOutput("rst_step_out", 32'(stepOut), 32'd0);
      checkOutput("rst_dir_out", 32'(dirOut), 32'd0);
      checkOutput("rst_position", position, 32'd0);
      checkOutput("rst_step_count", stepCount, 32'd0);
      checkOutput("rst_at_limit", 32'(atLimit), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);

      $display("[TB] steady stepping");
      applyStimulus(32'd1000, 32'd1, 1'b0, 1'b0);
      waitRise(1'b0, n);
      checkOutput("steady_first_rise", n, 32'd51);
      checkOutput("steady_dir_out", 32'(dirOut), 32'd1);
      checkOutput("steady_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         measurePeriod(hi, per);
         checkOutput("steady_high", hi, 32'd100);
         checkOutput("steady_period", per, 32'd1000);
      end
      checkOutput("steady_position", position, 32'd5);
      checkOutput("steady_step_count", stepCount, 32'd5);

      $display("[TB] direction reversal");
      n = 0;
      for (int i = 0; i < BOUND; i++) begin
         @(negedge clock);
         n++;
         if (n == 150) applyStimulus(32'd1000, 32'd0, 1'b0, 1'b0);
         if (!dirOut) break;
      end
      checkOutput("rev_dir_fall", n, 32'd1000);
      waitRise(1'b0, n);
      checkOutput("rev_setup_rise", n, 32'd50);
      checkOutput("rev_position", position, 32'd4);

      $display("[TB] period clamp");
      applyStimulus(32'd10, 32'd0, 1'b0, 1'b0);
      measurePeriod(hi, per);
      checkOutput("clamp_no_truncate", per, 32'd1000);
      for (int i = 0; i < 2; i++) begin
         measurePeriod(hi, per);
         checkOutput("clamp_high", hi, 32'd100);
         checkOutput("clamp_period", per, 32'd200);
      end
      checkOutput("clamp_position", position, 32'd1);

      $display("[TB] jog override");
      applyStimulus(32'd500, 32'd1, 1'b0, 1'b0);
      measurePeriod(hi, per);
      checkOutput("jog_pre_turn", per, 32'd250);
      measurePeriod(hi, per);
      checkOutput("jog_pre_period", per, 32'd500);
      applyStimulus(32'd500, 32'd1, 1'b0, 1'b1);
      measurePeriod(hi, per);
      checkOutput("jog_enter_period", per, 32'd550);
      checkOutput("jog_dir_out", 32'(dirOut), 32'd0);
      measurePeriod(hi, per);
      checkOutput("jog_period", per, TB_JOG);
      applyStimulus(32'd500, 32'd1, 1'b0, 1'b0);
      measurePeriod(hi, per);
      checkOutput("jog_release_period", per, 32'(TB_JOG + 50));
      checkOutput("jog_release_dir", 32'(dirOut), 32'd1);
      measurePeriod(hi, per);
      checkOutput("jog_resume_period", per, 32'd500);
      checkOutput("jog_position", position, 32'd3);
      checkOutput("jog_step_count", stepCount, 32'd15);

      $display("[TB] async reset mid-HIGH");
      repeat (20) @(negedge clock);
      checkOutput("arst_pre_high", 32'(stepOut), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("arst_step_out", 32'(stepOut), 32'd0);
      checkOutput("arst_position", position, 32'd0);
      checkOutput("arst_step_count", stepCount, 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      $display("[TB] limit axis: latency and zeroing");
      limSpeed = 32'd300;
      limDir   = 32'd0;
      waitRise(1'b1, n);
      checkOutput("lim_first_rise", n, 32'd1);
      checkOutput("lim_neg_position", limPosition, 32'hFFFF_FFFF);
      limSpeed = 32'd0;
      waitLimIdle();
      checkOutput("lim_idle_step_out", 32'(limStepOut), 32'd0);
      limSpeed = 32'd300;
      limZero  = 1'b1;
      @(negedge clock);
      limZero  = 1'b0;
      limSpeed = 32'd0;
      checkOutput("zero_on_entry_high", 32'(limStepOut), 32'd1);
      checkOutput("zero_on_entry_pos", limPosition, 32'd0);
      waitLimIdle();
      checkOutput("zero_step_count", limStepCount, 32'd2);

      $display("[TB] limit axis: soft limit");
      limSpeed  = 32'd300;
      limDir    = 32'd1;
      rises     = 0;
      firstRise = 0;
      prev      = limStepOut;
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clock);
         if (limStepOut && !prev) begin
            rises++;
            if (rises == 1) firstRise = i;
         end
         prev = limStepOut;
      end
      checkOutput("limit_pulses", rises, 32'd3);
      checkOutput("limit_first_rise", firstRise, 32'd51);
      checkOutput("limit_at_limit", 32'(limAtLimit), 32'd1);
      checkOutput("limit_position", limPosition, 32'd3);
      checkOutput("limit_step_out", 32'(limStepOut), 32'd0);
      checkOutput("limit_busy", 32'(limBusy), 32'd0);
      limDir = 32'd0;
      @(negedge clock);
      checkOutput("limit_clear", 32'(limAtLimit), 32'd0);
      checkOutput("limit_dir_out", 32'(limDirOut), 32'd0);
      waitRise(1'b1, n);
      checkOutput("limit_back_rise", n, 32'd50);
      checkOutput("limit_back_position", limPosition, 32'd2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
